uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter that consumes the debug unit's outgoing byte stream (dataToSend / writeFlag) and drives the serial TX pin.
- Sits directly downstream of the debug unit, on the transmit half of the UART path.
- Decouples pipeline-dump bursts (one byte per clock) from the slow serial line using a byte FIFO, a baud counter and a frame serializer.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); must be >= 2.
- FIFO_ADDR_W, 4, log2 of FIFO depth (default depth 16 bytes).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- writeFlag  in  1  push request; one byte accepted per asserted cycle.
- dataToSend  in  8  byte to push; sampled when writeFlag=1.
- uart_tx  out  1  serial line, registered; idle high.
- fifoFull  out  1  FIFO holds 2^FIFO_ADDR_W bytes.
- fifoEmpty  out  1  FIFO holds 0 bytes.
- fifoCount  out  FIFO_ADDR_W+1  current occupancy.
- txBusy  out  1  serializer is in any state other than IDLE.
- overflow  out  1  sticky; set when a push is dropped.

Behaviour:
- Reset values: uart_tx=1, fifoEmpty=1, fifoFull=0, fifoCount=0, txBusy=0, overflow=0; state=IDLE; pointers and baud counter = 0.
- Reset is asynchronous: asserting it mid-frame forces uart_tx high immediately and discards the FIFO contents and the partial frame.
- Push: accepted when writeFlag=1 and fifoFull=0 at that clock edge. Data is written at the write pointer, which then increments modulo the depth.
- Push while full: byte dropped, overflow set to 1 and held until reset.
- Fullness is judged on the registered flag, before any same-cycle pop. A push in the same cycle as a pop while full is therefore dropped.
- Pop: only the serializer pops. It reads the byte at the read pointer into an 8-bit shift register and increments the pointer modulo the depth.
- Simultaneous push and pop when not full: fifoCount is unchanged and both pointers advance.
- All flags are registered and consistent with fifoCount every cycle.
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If fifoEmpty=0, pop, clear the baud counter, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx = shift[0], LSB first. Every CLKS_PER_BIT cycles shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end, if fifoEmpty=0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps, giving exactly CLKS_PER_BIT cycles per bit. A frame is 10*CLKS_PER_BIT cycles.
- Latency: push at edge N makes fifoEmpty=0 after N. IDLE pops at N+1, and uart_tx falls at edge N+2.
- txBusy=1 from the pop edge until the STOP→IDLE transition.
- writeFlag held high for many cycles pushes one byte per cycle until the FIFO is full.

Decomposition:
- Shared package uart_pkg:
  - state encoding IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - DATA_BITS=8;
  - default CLKS_PER_BIT and FIFO_ADDR_W constants.
- Sub-module uart_byte_fifo (synchronous FIFO with count, full, empty and overflow).
- The serializer FSM and baud counter stay in uart_tx_buffered.

Test Plan:
- CLKS_PER_BIT=4; push 0x55 in a single cycle at edge N → uart_tx low at N+2 for 4 cycles, then data bits 1,0,1,0,1,0,1,0 of 4 cycles each, then high 4 cycles; txBusy falls at N+42.
- Push 0xA3, 0x0F, 0xFF on 3 consecutive cycles → fifoCount peaks at 2 (one popped immediately); three frames back-to-back with exactly 4 stop cycles between start bits; total 120 cycles of activity.
- With the serializer busy, push 17 bytes 0x00..0x10 → fifoFull=1 after 16 pushes. Byte 0x10 is dropped and overflow=1. The line later emits the in-flight byte followed by queued bytes in order, never 0x10.
- FIFO full and STOP ending (pop) in the same cycle as a push of 0x77 → push dropped, overflow=1, fifoCount=15 after the edge.
- Assert reset during the DATA state of byte 0xC4 with 5 bytes queued → uart_tx=1 asynchronously, fifoEmpty=1, fifoCount=0, overflow=0. After release no frame starts until a new push.
- Idle line for 100 cycles with no push → uart_tx stays 1, txBusy=0, fifoEmpty=1.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg - shared constants and serializer state type              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_FIFO_ADDR_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_byte_fifo - synchronous byte FIFO, registered flags/count     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_FIFO_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [7:0]        push_data,
  input  logic              pop,
  output logic [7:0]        pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W + 1)'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic [ADDR_W:0]   count_next;

  // Fullness uses the registered flag, so a push is refused even if a pop
  // frees a slot on the same edge.
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + ONE_CNT;
    else if (pop_ok && !push_ok)
      count_next = count - ONE_CNT;
  end

  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      full     <= (count_next == DEPTH_CNT);
      empty    <= (count_next == '0);
      overflow <= overflow | (push && full);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_buffered - FIFO-buffered 8N1 UART transmitter              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_ADDR_W  = DEFAULT_FIFO_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  writeFlag,
  input  logic [7:0]            dataToSend,
  output logic                  uart_tx,
  output logic                  fifoFull,
  output logic                  fifoEmpty,
  output logic [FIFO_ADDR_W:0]  fifoCount,
  output logic                  txBusy,
  output logic                  overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [7:0]        fifo_data;
  logic              baud_done;
  logic              pop;

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign pop       = !fifoEmpty && ((state == IDLE) || ((state == STOP) && baud_done));

  uart_byte_fifo #(
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (writeFlag),
    .push_data (dataToSend),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .count     (fifoCount),
    .overflow  (overflow)
  );

  // uart_tx follows the state one cycle late, so txBusy is likewise held
  // until the last stop-bit cycle has actually left the pin.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
      txBusy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx  <= 1'b1;
          txBusy   <= pop;
          baud_cnt <= '0;
          if (pop) begin
            shift <= fifo_data;
            state <= START;
          end
        end
        START: begin
          uart_tx <= 1'b0;
          txBusy  <= 1'b1;
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          uart_tx <= shift[0];
          txBusy  <= 1'b1;
          if (baud_done) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == LAST_BIT)
              state <= STOP;
            else
              bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          uart_tx <= 1'b1;
          txBusy  <= 1'b1;
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= fifo_data;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_tx_buffered - bench with frame-timing reference model      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int FRAME = 10 * CPB;

  logic          clock;
  logic          reset;
  logic          writeFlag;
  logic [7:0]    dataToSend;
  logic          uart_tx;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [AW:0]   fifoCount;
  logic          txBusy;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of accepted bytes plus the edge of the last pop.
  // A frame occupies the line for FRAME edges after its pop edge.
  logic [7:0] q[$];
  logic [7:0] cur_byte;
  int         edge_k;
  int         pop_edge;
  int         next_pop;
  logic       m_ovf;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_ADDR_W  (AW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .writeFlag  (writeFlag),
    .dataToSend (dataToSend),
    .uart_tx    (uart_tx),
    .fifoFull   (fifoFull),
    .fifoEmpty  (fifoEmpty),
    .fifoCount  (fifoCount),
    .txBusy     (txBusy),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_k, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    cur_byte = 8'h00;
    pop_edge = -1000;
    next_pop = 0;
    m_ovf    = 1'b0;
  endtask

  function automatic logic exp_tx();
    int off;
    int b;
    off = edge_k - pop_edge - 1;
    if (off < 0 || off >= FRAME) return 1'b1;
    b = off / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur_byte[b-1];
  endfunction

  function automatic logic exp_busy();
    return (edge_k >= pop_edge) && (edge_k <= pop_edge + FRAME);
  endfunction

  task automatic model_edge(input logic wf, input logic [7:0] d);
    logic can_pop;
    logic can_push;
    can_pop  = (q.size() > 0) && (edge_k >= next_pop);
    can_push = wf && (q.size() < DEPTH);
    if (wf && !can_push) m_ovf = 1'b1;
    if (can_pop) begin
      cur_byte = q.pop_front();
      pop_edge = edge_k;
      next_pop = edge_k + FRAME;
    end
    if (can_push) q.push_back(d);
  endtask

  task automatic check_all();
    chk("uart_tx",   32'(uart_tx),   32'(exp_tx()));
    chk("txBusy",    32'(txBusy),    32'(exp_busy()));
    chk("fifoCount", 32'(fifoCount), 32'(q.size()));
    chk("fifoFull",  32'(fifoFull),  32'(q.size() == DEPTH));
    chk("fifoEmpty", 32'(fifoEmpty), 32'(q.size() == 0));
    chk("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  task automatic tick(input logic wf, input logic [7:0] d);
    writeFlag  = wf;
    dataToSend = d;
    @(posedge clock);
    edge_k++;
    model_edge(wf, d);
    #1;
    writeFlag = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    m_reset();
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    int n;
    int peak;
    reset      = 1'b1;
    writeFlag  = 1'b0;
    dataToSend = 8'h00;
    edge_k     = 0;
    m_reset();
    @(posedge clock);
    #1;
    chk("rst_tx",    32'(uart_tx),   32'd1);
    chk("rst_empty", 32'(fifoEmpty), 32'd1);
    chk("rst_full",  32'(fifoFull),  32'd0);
    chk("rst_count", 32'(fifoCount), 32'd0);
    chk("rst_busy",  32'(txBusy),    32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
    do_reset();

    // Single byte 0x55: start bit at N+2, busy drops at N+42
    tick(1'b1, 8'h55);
    n = edge_k;
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 8'h00);
      if (edge_k == n + 2)  chk("t1_start_low", 32'(uart_tx), 32'd0);
      if (edge_k == n + 41) chk("t1_busy_hi",   32'(txBusy),  32'd1);
      if (edge_k == n + 42) chk("t1_busy_lo",   32'(txBusy),  32'd0);
    end

    // Three consecutive pushes, back-to-back frames
    peak = 0;
    tick(1'b1, 8'hA3);
    tick(1'b1, 8'h0F);
    if (int'(fifoCount) > peak) peak = int'(fifoCount);
    tick(1'b1, 8'hFF);
    if (int'(fifoCount) > peak) peak = int'(fifoCount);
    for (int i = 0; i < 125; i++) begin
      tick(1'b0, 8'h00);
      if (int'(fifoCount) > peak) peak = int'(fifoCount);
    end
    chk("t2_peak", 32'(peak), 32'd2);

    // Fill while busy: 17 pushes, the last one (0x10) dropped
    tick(1'b1, 8'($urandom));
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, 8'(i));
      if (i == 15) chk("t3_full", 32'(fifoFull), 32'd1);
    end
    chk("t3_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 17 * FRAME + 10; i++) tick(1'b0, 8'h00);

    // Push while full on the same edge the stop bit ends and pops
    do_reset();
    tick(1'b1, 8'($urandom));
    for (int i = 0; i < 16; i++) tick(1'b1, 8'($urandom));
    chk("t4_full", 32'(fifoFull), 32'd1);
    while (edge_k + 1 < next_pop) tick(1'b0, 8'h00);
    tick(1'b1, 8'h77);
    chk("t4_count", 32'(fifoCount), 32'd15);
    chk("t4_ovf",   32'(overflow),  32'd1);
    for (int i = 0; i < 20; i++) tick(1'b0, 8'h00);

    // Asynchronous reset in the middle of 0xC4's data bits
    do_reset();
    tick(1'b1, 8'hC4);
    for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom));
    while (edge_k < pop_edge + 6) tick(1'b0, 8'h00);
    chk("t5_pre_low", 32'(uart_tx), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_tx",    32'(uart_tx),   32'd1);
    chk("t5_async_empty", 32'(fifoEmpty), 32'd1);
    chk("t5_async_count", 32'(fifoCount), 32'd0);
    chk("t5_async_busy",  32'(txBusy),    32'd0);
    chk("t5_async_ovf",   32'(overflow),  32'd0);
    do_reset();

    // Idle line: no frame may start without a push
    for (int i = 0; i < 100; i++) tick(1'b0, 8'h00);
    chk("t6_tx",    32'(uart_tx),   32'd1);
    chk("t6_empty", 32'(fifoEmpty), 32'd1);

    // Random traffic with bursts and overflows
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        tick(1'b1, 8'($urandom));
      else
        tick(1'b0, 8'h00);
    end
    for (int i = 0; i < 20; i++) tick(1'b1, 8'($urandom));
    for (int i = 0; i < DEPTH * FRAME + 60; i++) tick(1'b0, 8'h00);
    chk("end_empty", 32'(fifoEmpty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
